// File: rtl/seq_alu.sv
// Handshaked ALU with registered results: single-cycle logic/arith ops plus
// iterative unsigned multiply (shift/add) and restoring divide (shift/subtract).
module seq_alu #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic             dbz
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_DIV = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_mul_q, is_mul_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             negative_q, negative_d;
   logic             overflow_q, overflow_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   add_w, sub_w, mul_sum, div_sh;
   logic [WIDTH-1:0] div_sub, mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic             mul_top, div_ge;
   logic             load;
   logic [WIDTH-1:0] fin_res, fin_hi;
   logic             fin_carry, fin_ovf, fin_dbz;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_mul_d    = is_mul_q;
      opnd_d      = opnd_q;
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      hi_d        = hi_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      negative_d  = negative_q;
      overflow_d  = overflow_q;
      dbz_d       = dbz_q;
      load        = 1'b0;
      fin_res     = '0;
      fin_hi      = '0;
      fin_carry   = 1'b0;
      fin_ovf     = 1'b0;
      fin_dbz     = 1'b0;

      add_w = {1'b0, a} + {1'b0, b};
      sub_w = {1'b0, a} - {1'b0, b};

      // MUL step: acc_lo holds the multiplier, shifted out LSB-first as product bits arrive
      mul_sum = {1'b0, acc_hi_q} + {1'b0, opnd_q};
      if (acc_lo_q[0]) {mul_top, mul_hi_n, mul_lo_n} = {1'b0, mul_sum, acc_lo_q[WIDTH-1:1]};
      else             {mul_top, mul_hi_n, mul_lo_n} = {2'b00, acc_hi_q, acc_lo_q[WIDTH-1:1]};

      // DIV step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
      div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_ge   = div_sh >= {1'b0, opnd_q};
      div_sub  = div_sh[WIDTH-1:0] - opnd_q;
      div_hi_n = div_ge ? div_sub : div_sh[WIDTH-1:0];
      div_lo_n = {acc_lo_q[WIDTH-2:0], div_ge};

      step_hi = is_mul_q ? mul_hi_n : div_hi_n;
      step_lo = is_mul_q ? mul_lo_n : div_lo_n;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                  state_d  = S_BUSY;
                  cnt_d    = '0;
                  is_mul_d = (op == OP_MUL);
                  opnd_d   = (op == OP_MUL) ? a : b;
                  acc_hi_d = '0;
                  acc_lo_d = (op == OP_MUL) ? b : a;
               end else begin
                  load = 1'b1;
                  unique case (op)
                     OP_ADD: begin
                        fin_res   = add_w[WIDTH-1:0];
                        fin_carry = add_w[WIDTH];
                        fin_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
                     end
                     OP_SUB: begin
                        fin_res   = sub_w[WIDTH-1:0];
                        fin_carry = sub_w[WIDTH];
                        fin_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
                     end
                     OP_AND: fin_res = a & b;
                     OP_OR:  fin_res = a | b;
                     OP_XOR: fin_res = a ^ b;
                     OP_SLT: fin_res[0] = $signed(a) < $signed(b);
                     default: begin
                        fin_res = '1;
                        fin_hi  = a;
                        fin_dbz = 1'b1;
                     end
                  endcase
               end
            end
         end
         S_BUSY: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               load      = 1'b1;
               fin_res   = step_lo;
               fin_hi    = step_hi;
               fin_carry = is_mul_q && (step_hi != '0);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         state_d     = S_DONE;
         out_valid_d = 1'b1;
         result_d    = fin_res;
         hi_d        = fin_hi;
         zero_d      = (fin_res == '0);
         carry_d     = fin_carry;
         negative_d  = fin_res[WIDTH-1];
         overflow_d  = fin_ovf;
         dbz_d       = fin_dbz;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         is_mul_q    <= 1'b0;
         opnd_q      <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         hi_q        <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         negative_q  <= 1'b0;
         overflow_q  <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_mul_q    <= is_mul_d;
         opnd_q      <= opnd_d;
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         hi_q        <= hi_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         negative_q  <= negative_d;
         overflow_q  <= overflow_d;
         dbz_q       <= dbz_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign hi        = hi_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign negative  = negative_q;
   assign overflow  = overflow_q;
   assign dbz       = dbz_q;

endmodule
